// File: rtl/grey_decade_decoder.sv
// Registers the Gray-coded ones/tens digits of a decade counter, decodes them to 0-99,
// checks every sample-to-sample transition and drives a two-digit multiplexed 7-seg display.
module grey_decade_decoder #(
  parameter int MUX_BITS = 10,
  parameter int ERR_W    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_ones,
  input  logic [4:0]       i_tens,
  output logic [6:0]       o_bin,
  output logic             o_valid,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [6:0]       o_seg,
  output logic             o_dig_sel
);

  // {valid, digit}; any code outside the table decodes as invalid
  function automatic logic [4:0] gray_dec(input logic [4:0] c);
    logic [4:0] r;
    case (c)
      5'b00000: r = {1'b1, 4'd0};
      5'b00001: r = {1'b1, 4'd1};
      5'b00011: r = {1'b1, 4'd2};
      5'b00010: r = {1'b1, 4'd3};
      5'b00110: r = {1'b1, 4'd4};
      5'b00100: r = {1'b1, 4'd5};
      5'b01100: r = {1'b1, 4'd6};
      5'b01000: r = {1'b1, 4'd7};
      5'b11000: r = {1'b1, 4'd8};
      5'b10000: r = {1'b1, 4'd9};
      default:  r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  function automatic logic [6:0] seg_pat(input logic ok, input logic [3:0] d);
    logic [6:0] p;
    p = 7'h40;
    if (ok) begin
      case (d)
        4'd0:    p = 7'h3F;
        4'd1:    p = 7'h06;
        4'd2:    p = 7'h5B;
        4'd3:    p = 7'h4F;
        4'd4:    p = 7'h66;
        4'd5:    p = 7'h6D;
        4'd6:    p = 7'h7D;
        4'd7:    p = 7'h07;
        4'd8:    p = 7'h7F;
        4'd9:    p = 7'h6F;
        default: p = 7'h40;
      endcase
    end
    return p;
  endfunction

  logic [4:0]          cur_ones, cur_tens, prev_ones, prev_tens;
  logic                cur_ld;   // cur holds a real sample rather than the reset value
  logic                primed;
  logic [MUX_BITS-1:0] mux_cnt;

  logic [4:0]          dco, dct, dpo, dpt;
  logic                cur_ok, prev_ok;
  logic [3:0]          co, ct, po, pt, pt_succ;
  logic                legal, illegal;
  logic [MUX_BITS-1:0] mux_nxt;
  logic                sel_nxt;
  logic [6:0]          seg_nxt;

  always_comb begin
    dco     = gray_dec(cur_ones);
    dct     = gray_dec(cur_tens);
    dpo     = gray_dec(prev_ones);
    dpt     = gray_dec(prev_tens);
    co      = dco[3:0];
    ct      = dct[3:0];
    po      = dpo[3:0];
    pt      = dpt[3:0];
    cur_ok  = dco[4] & dct[4];
    prev_ok = dpo[4] & dpt[4];
    pt_succ = (pt == 4'd9) ? 4'd0 : pt + 4'd1;
    // (0,0) is always accepted so an upstream reset resynchronises silently
    legal   = cur_ok &&
              (((co == 4'd0) && (ct == 4'd0)) ||
               (prev_ok &&
                (((co == po) && (ct == pt)) ||
                 ((po != 4'd9) && (co == po + 4'd1) && (ct == pt)) ||
                 ((po == 4'd9) && (co == 4'd0) && (ct == pt_succ)))));
    illegal = cur_ld && (!cur_ok || (primed && !legal));
    mux_nxt = mux_cnt + {{(MUX_BITS-1){1'b0}}, 1'b1};
    sel_nxt = mux_nxt[MUX_BITS-1];
    seg_nxt = sel_nxt ? seg_pat(dct[4], ct) : seg_pat(dco[4], co);
  end

  assign o_dig_sel = mux_cnt[MUX_BITS-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur_ones  <= '0;
      cur_tens  <= '0;
      prev_ones <= '0;
      prev_tens <= '0;
      cur_ld    <= 1'b0;
      primed    <= 1'b0;
      mux_cnt   <= '0;
      o_bin     <= '0;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
      o_seg     <= '0;
    end else begin
      prev_ones <= cur_ones;
      prev_tens <= cur_tens;
      cur_ones  <= i_ones;
      cur_tens  <= i_tens;
      cur_ld    <= 1'b1;
      mux_cnt   <= mux_nxt;
      o_seg     <= seg_nxt;
      if (cur_ld) begin
        primed  <= 1'b1;
        o_valid <= cur_ok;
        if (cur_ok) o_bin <= 7'(ct) * 7'd10 + 7'(co);
      end
      if (illegal) begin
        o_err <= 1'b1;
        if (o_err_cnt != {ERR_W{1'b1}}) o_err_cnt <= o_err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_grey_decade_decoder.sv
// Directed bench for grey_decade_decoder: one default instance and one with a
// 2-bit refresh counter and 2-bit error counter, both fed the same inputs.
module tb_grey_decade_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] ones = 5'b0, tens = 5'b0;

  logic [6:0] bin_a, seg_a, bin_b, seg_b;
  logic       valid_a, err_a, sel_a, valid_b, err_b, sel_b;
  logic [3:0] cnt_a;
  logic [1:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  grey_decade_decoder #(.MUX_BITS(10), .ERR_W(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_ones(ones), .i_tens(tens),
    .o_bin(bin_a), .o_valid(valid_a), .o_err(err_a), .o_err_cnt(cnt_a),
    .o_seg(seg_a), .o_dig_sel(sel_a)
  );

  grey_decade_decoder #(.MUX_BITS(2), .ERR_W(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_ones(ones), .i_tens(tens),
    .o_bin(bin_b), .o_valid(valid_b), .o_err(err_b), .o_err_cnt(cnt_b),
    .o_seg(seg_b), .o_dig_sel(sel_b)
  );

  function automatic logic [4:0] gc(input int d);
    case (d)
      0: return 5'b00000;
      1: return 5'b00001;
      2: return 5'b00011;
      3: return 5'b00010;
      4: return 5'b00110;
      5: return 5'b00100;
      6: return 5'b01100;
      7: return 5'b01000;
      8: return 5'b11000;
      default: return 5'b10000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_raw(input logic [4:0] o, input logic [4:0] t);
    ones = o;
    tens = t;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step(input int v);
    step_raw(gc(v % 10), gc(v / 10));
  endtask

  task automatic reset_step(input int v);
    rst = 1'b1;
    step(v);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_bin_a"}, 32'(bin_a), 0);
    check({tag, "_valid_a"}, 32'(valid_a), 0);
    check({tag, "_err_a"}, 32'(err_a), 0);
    check({tag, "_cnt_a"}, 32'(cnt_a), 0);
    check({tag, "_seg_a"}, 32'(seg_a), 0);
    check({tag, "_sel_a"}, 32'(sel_a), 0);
    check({tag, "_cnt_b"}, 32'(cnt_b), 0);
    check({tag, "_seg_b"}, 32'(seg_b), 0);
    check({tag, "_sel_b"}, 32'(sel_b), 0);
  endtask

  initial begin
    // reset state
    reset_step(0);
    check_reset("rst");

    // full count 00 -> 99 -> 00..., outputs lag the driven value by one step here
    for (int i = 0; i < 205; i++) begin
      step(i % 100);
      if (i >= 1) begin
        check("cnt_bin", 32'(bin_a), 32'((i - 1) % 100));
        check("cnt_valid", 32'(valid_a), 1);
        check("cnt_err", 32'(err_a), 0);
      end
    end
    check("cnt_errcnt", 32'(cnt_a), 0);

    // invalid ones code after 42
    for (int i = 0; i <= 42; i++) step(i);
    step(42);
    check("pre_inv_bin", 32'(bin_a), 42);
    step_raw(5'b00101, gc(4));
    step(42);
    check("inv_valid", 32'(valid_a), 0);
    check("inv_bin", 32'(bin_a), 42);
    check("inv_err", 32'(err_a), 1);
    check("inv_errcnt", 32'(cnt_a), 1);
    check("inv_sel", 32'(sel_a), 32'(cyc[9]));
    check("inv_seg", 32'(seg_a), 32'h40);
    step(43);
    check("ret_errcnt", 32'(cnt_a), 2);
    check("ret_err", 32'(err_a), 1);
    check("ret_valid", 32'(valid_a), 1);
    step(44);
    check("ret_bin", 32'(bin_a), 43);
    check("ret_errcnt2", 32'(cnt_a), 2);

    // skipped step 3 -> 5
    step(0);
    for (int i = 1; i <= 3; i++) step(i);
    step(5);
    step(5);
    check("skip_errcnt", 32'(cnt_a), 3);
    step(5);
    check("skip_hold_cnt", 32'(cnt_a), 3);
    check("skip_hold_bin", 32'(bin_a), 5);

    // ones wrap 19 -> 10 without tens advance
    step(0);
    for (int i = 1; i <= 19; i++) step(i);
    step(10);
    step(10);
    check("wrap_errcnt", 32'(cnt_a), 4);
    step(11);
    check("wrap_hold_cnt", 32'(cnt_a), 4);
    check("wrap_hold_bin", 32'(bin_a), 10);

    // resync to zero from 57
    step(0);
    for (int i = 1; i <= 57; i++) step(i);
    step(0);
    check("resync_pre_bin", 32'(bin_a), 57);
    step(1);
    check("resync_bin", 32'(bin_a), 0);
    check("resync_errcnt", 32'(cnt_a), 4);
    step(2);
    check("resync_bin1", 32'(bin_a), 1);
    check("resync_errcnt1", 32'(cnt_a), 4);
    check("sticky_err", 32'(err_a), 1);
    check("sat_b_early", 32'(cnt_b), 3);

    // display mux on the small instance, value 38
    step(0);
    for (int i = 1; i <= 38; i++) step(i);
    for (int k = 0; k < 8; k++) begin
      step(38);
      check("mux_sel", 32'(sel_b), 32'(cyc[1]));
      check("mux_seg", 32'(seg_b), cyc[1] ? 32'h4F : 32'h7F);
    end

    // saturation: five invalid cycles after a fresh reset
    reset_step(0);
    check_reset("rst2");
    step(0);
    for (int k = 0; k < 5; k++) step_raw(5'b00101, 5'b00000);
    step(0);
    step(0);
    check("sat_cnt_b", 32'(cnt_b), 3);
    check("sat_cnt_a", 32'(cnt_a), 5);
    check("sat_err_b", 32'(err_b), 1);
    check("sat_valid", 32'(valid_a), 1);
    check("sat_bin", 32'(bin_a), 0);

    // reset mid-count, then first sample 71 is not flagged
    for (int i = 1; i <= 30; i++) step(i);
    rst = 1'b1;
    step(71);
    rst = 1'b0;
    cyc = 0;
    check_reset("rst3");
    check("rst3_err_b", 32'(err_b), 0);
    step(71);
    step(71);
    check("post_bin", 32'(bin_a), 71);
    check("post_valid", 32'(valid_a), 1);
    check("post_err", 32'(err_a), 0);
    check("post_cnt", 32'(cnt_a), 0);
    step(72);
    check("post_err1", 32'(err_a), 0);
    step(73);
    check("post_bin2", 32'(bin_a), 72);
    check("post_err2", 32'(err_a), 0);
    check("post_err_b", 32'(err_b), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
